// File: rtl/tt_fifo_pkg.sv
// rtl/tt_fifo_pkg.sv - shared FIFO sizing, status bit positions and pad-direction constant
// Contents: DATA_W, DEPTH, PTR_W, CNT_W, uio_out bit indices, UIO_OE.
package tt_fifo_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // uio_out status field positions
  localparam int BIT_FULL   = 3;
  localparam int BIT_EMPTY  = 4;
  localparam int BIT_CNT_LO = 5;
  localparam int BIT_CNT_HI = 9;
  localparam int BIT_OVF    = 10;
  localparam int BIT_UNF    = 11;
  localparam int BIT_AF     = 12;
  localparam int BIT_AE     = 13;

  // bits [2:0] are control inputs, the rest drive status
  localparam logic [15:0] UIO_OE = 16'hFFF8;

endpackage

// File: rtl/fifo_core.sv
// rtl/fifo_core.sv - synchronous FIFO core: storage, pointers, count, sticky errors, flags
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wr, rd, flush      already-qualified requests (enable gating done by the caller)
//   din / dout         write data / registered read data (holds when no read)
//   count              occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty  decodes of count
//   overflow, underflow                     sticky error flags, cleared by flush or reset
module fifo_core
  import tt_fifo_pkg::*;
#(
  parameter int DATA_W = tt_fifo_pkg::DATA_W,
  parameter int DEPTH  = tt_fifo_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic                       rd,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic rd_ok;
  logic wr_ok;

  // A read frees a slot in the same edge, so a write to a full FIFO is
  // accepted when paired with a read; the read sees the old word because
  // memory is updated non-blocking.
  assign rd_ok = rd && !empty && !flush;
  assign wr_ok = wr && (!full || rd) && !flush;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(DEPTH - 2));
  assign almost_empty = (count <= CW'(2));

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_example.sv
// rtl/tt_um_example.sv - FIFO top: pin mapping and enable gating around fifo_core
// Ports:
//   clk, rst_n   clock; rst_n is an asynchronous ACTIVE-HIGH reset despite its name
//   ena          block enable, gates wr/rd/flush
//   ui_in        write data
//   uio_in       [0] wr_en, [1] rd_en, [2] flush
//   uo_out       registered read data
//   uio_out      status word (full, empty, count, overflow, underflow, almost flags)
//   uio_oe       constant pad directions
module tt_um_example
  import tt_fifo_pkg::*;
#(
  parameter int DATA_W = tt_fifo_pkg::DATA_W,
  parameter int DEPTH  = tt_fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [15:0]       uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [15:0]       uio_out,
  output logic [15:0]       uio_oe
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr;
  logic          rd;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic          unused_ctrl;

  assign wr          = ena && uio_in[0];
  assign rd          = ena && uio_in[1];
  assign flush       = ena && uio_in[2];
  assign unused_ctrl = &{1'b0, uio_in[15:3]};

  fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk          (clk),
    .rst          (rst_n),
    .wr           (wr),
    .rd           (rd),
    .flush        (flush),
    .din          (ui_in),
    .dout         (uo_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always_comb begin
    uio_out                        = '0;
    uio_out[BIT_FULL]              = full;
    uio_out[BIT_EMPTY]             = empty;
    uio_out[BIT_CNT_HI:BIT_CNT_LO] = 5'(count);
    uio_out[BIT_OVF]               = overflow;
    uio_out[BIT_UNF]               = underflow;
    uio_out[BIT_AF]                = almost_full;
    uio_out[BIT_AE]                = almost_empty;
  end

  assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_tt_um_example.sv
// tb/tb_tt_um_example.sv - randomized self-checking bench for tt_um_example against a queue model
module tb_tt_um_example;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [15:0] ui_in = '0;
  logic [15:0] uio_in = '0;
  logic [15:0] uo_out;
  logic [15:0] uio_out;
  logic [15:0] uio_oe;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] q[$];
  logic [15:0] m_dout;
  logic        m_ovf;
  logic        m_unf;

  tt_um_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status();
    int n;
    logic [15:0] s;
    n = q.size();
    s = '0;
    s[3]   = (n == 16);
    s[4]   = (n == 0);
    s[9:5] = 5'(n);
    s[10]  = m_ovf;
    s[11]  = m_unf;
    s[12]  = (n >= 14);
    s[13]  = (n <= 2);
    return s;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_dout"}, {16'h0, uo_out}, {16'h0, m_dout});
    check({tag, "_stat"}, {16'h0, uio_out}, {16'h0, exp_status()});
  endtask

  // Called at a negedge: drive, take one rising edge, update model, check at next negedge.
  task automatic step(input logic en, input logic wr, input logic rd,
                      input logic fl, input logic [15:0] d, input string tag);
    bit was_full, was_empty, rd_ok, wr_ok;
    ena    = en;
    ui_in  = d;
    uio_in = {13'h1FFF & 13'($urandom), fl, rd, wr};
    @(posedge clk);
    if (en) begin
      if (fl) begin
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        rd_ok = rd && !was_empty;
        wr_ok = wr && (!was_full || rd);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        if (wr && was_full && !rd) m_ovf = 1'b1;
        if (rd && was_empty) m_unf = 1'b1;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic do_reset(input string tag);
    ena    = 1'b0;
    uio_in = '0;
    #2;
    rst_n = 1'b1;
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    #1;
    check_all({tag, "_async"});
    @(negedge clk);
    rst_n = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] pat;
    int phase;
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    @(negedge clk);
    do_reset("rst0");
    step(1, 0, 0, 0, 16'h0, "idle");
    check("oe", {16'h0, uio_oe}, 32'h0000_FFF8);
    check("idle_dout", {16'h0, uo_out}, 32'h0);
    check("idle_empty", {31'h0, uio_out[4]}, 32'h1);

    // three writes, three reads
    step(1, 1, 0, 0, 16'h1111, "w1");
    step(1, 1, 0, 0, 16'h2222, "w2");
    step(1, 1, 0, 0, 16'h3333, "w3");
    step(1, 0, 1, 0, 16'h0, "r1");
    check("r1_val", {16'h0, uo_out}, 32'h1111);
    step(1, 0, 1, 0, 16'h0, "r2");
    check("r2_val", {16'h0, uo_out}, 32'h2222);
    step(1, 0, 1, 0, 16'h0, "r3");
    check("r3_val", {16'h0, uo_out}, 32'h3333);
    check("r3_empty", {31'h0, uio_out[4]}, 32'h1);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 16'(i), "fill");
    check("fill_full", {31'h0, uio_out[3]}, 32'h1);
    check("fill_cnt", {27'h0, uio_out[9:5]}, 32'd16);
    step(1, 1, 0, 0, 16'hFFFF, "ovf");
    check("ovf_flag", {31'h0, uio_out[10]}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 0, 16'h0, "drain");
      check("drain_val", {16'h0, uo_out}, 32'(i));
    end

    // underflow, then simultaneous rd+wr on empty
    step(1, 0, 1, 0, 16'h0, "unf");
    check("unf_flag", {31'h0, uio_out[11]}, 32'h1);
    check("unf_hold", {16'h0, uo_out}, 32'h000F);
    step(1, 1, 1, 0, 16'hABCD, "rw_empty");
    check("rw_empty_cnt", {27'h0, uio_out[9:5]}, 32'd1);
    step(1, 0, 1, 0, 16'h0, "rw_empty_rd");
    check("rw_empty_val", {16'h0, uo_out}, 32'hABCD);

    // full with 20 cycles of simultaneous rd+wr across pointer wrap
    step(1, 0, 0, 1, 16'h0, "flush0");
    pat = 16'h0100;
    for (int i = 0; i < 16; i++) begin step(1, 1, 0, 0, pat, "fill2"); pat++; end
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, 0, pat, "rw_full"); pat++;
      check("rw_full_val", {16'h0, uo_out}, 32'(16'h0100 + 16'(i)));
      check("rw_full_cnt", {27'h0, uio_out[9:5]}, 32'd16);
    end
    check("rw_full_ovf", {31'h0, uio_out[10]}, 32'h0);

    // flush mid-stream, ena gating, reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 16'(i + 7), "w5");
    step(1, 1, 1, 1, 16'h5555, "flush");
    check("flush_cnt", {27'h0, uio_out[9:5]}, 32'd0);
    step(0, 1, 0, 0, 16'h7777, "ena_off");
    check("ena_off_cnt", {27'h0, uio_out[9:5]}, 32'd0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 16'(i + 9), "w5b");
    do_reset("rst_mid");
    check("rst_mid_empty", {31'h0, uio_out[4]}, 32'h1);
    step(1, 1, 0, 0, 16'h5A5A, "post_rst_w");
    step(1, 0, 1, 0, 16'h0, "post_rst_r");
    check("post_rst_val", {16'h0, uo_out}, 32'h5A5A);

    // randomized traffic with biased fill/drain phases
    phase = 0;
    for (int i = 0; i < 800; i++) begin
      logic en, wr, rd, fl;
      if (i % 40 == 0) phase = $urandom_range(0, 2);
      en = ($urandom % 8) != 0;
      wr = (phase == 0) ? (($urandom % 4) != 0) : (phase == 1) ? (($urandom % 4) == 0) : 1'($urandom);
      rd = (phase == 1) ? (($urandom % 4) != 0) : (phase == 0) ? (($urandom % 4) == 0) : 1'($urandom);
      fl = ($urandom % 64) == 0;
      step(en, wr, rd, fl, 16'($urandom), "rand");
      if (i % 250 == 249) do_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_example.md
TT_UM_EXAMPLE -- requirements
Module: tt_um_example

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports are named clk and rst_n as the codebase does, and rst_n=1 resets despite the suffix.
REQ-002 Parameter DATA_W, default 16, SHALL set the FIFO word width.
REQ-003 Parameter DEPTH, default 16 (power of two), SHALL set the number of FIFO entries.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-high reset.
REQ-006 ena  input  1  block enable; when 0, write, read and flush requests are ignored and state holds.
REQ-007 ui_in  input  16  write data.
REQ-008 uio_in  input  16  control: [0] wr_en, [1] rd_en, [2] flush; [15:3] ignored.
REQ-009 uo_out  output  16  registered read data.
REQ-010 uio_out  output  16  status: [2:0]=0, [3] full, [4] empty, [9:5] count (0..16), [10] overflow, [11] underflow, [12] almost_full, [13] almost_empty, [15:14]=0.
REQ-011 uio_oe  output  16  constant 16'hFFF8: bits [2:0] inputs, rest outputs.

Function
REQ-012 The block SHALL be a synchronous FIFO: first word written is first word read.
REQ-013 Write: at a rising edge with ena=1, wr_en=1 and not full, ui_in SHALL be stored and count incremented.
REQ-014 Read: at a rising edge with ena=1, rd_en=1 and not empty, the oldest word SHALL be loaded into uo_out and count decremented; read latency is one clock (no fall-through).
REQ-015 uo_out SHALL hold its last value when no read occurs.
REQ-016 Simultaneous wr_en and rd_en with 0<count<DEPTH: both SHALL occur and count is unchanged.
REQ-017 Simultaneous wr_en and rd_en when full: the read SHALL occur and the write SHALL also be accepted; count stays DEPTH.
REQ-018 Simultaneous wr_en and rd_en when empty: the write SHALL be accepted, the read ignored, and uo_out unchanged.
REQ-019 Write while full, without a read, SHALL be dropped and set sticky overflow.
REQ-020 Read while empty SHALL be ignored and set sticky underflow.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be a separate 5-bit register.
REQ-022 full = (count==DEPTH); empty = (count==0); almost_full = (count>=DEPTH-2); almost_empty = (count<=2).
REQ-023 All flags SHALL be combinational decodes of registered state and reflect the update of the same edge.
REQ-024 flush (with ena=1) SHALL take priority over wr_en and rd_en at that edge: pointers and count become 0, overflow and underflow clear, and uo_out holds.

Reset
REQ-025 Reset SHALL asynchronously clear pointers, count, overflow, underflow and uo_out to 0, giving empty=1, almost_empty=1 and all other flags 0.
REQ-026 Storage array contents need not be reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored words, and the first read after release SHALL return the first post-reset write.

Structure
REQ-028 Package tt_fifo_pkg SHALL hold DATA_W, DEPTH, the pointer width, the count width, the uio_out bit indices, and the UIO_OE constant.
REQ-029 Sub-module fifo_core (memory, pointers, count, flags) SHALL be instantiated by tt_um_example, which does only pin mapping and the ena gating.

Verification
REQ-030 Reset then idle -> uo_out=0, empty=1, count=0, full=0, uio_oe=16'hFFF8.
REQ-031 Write 0x1111,0x2222,0x3333, then three reads -> uo_out=0x1111, 0x2222, 0x3333 on successive cycles after each read edge, ending with empty=1.
REQ-032 Write 16 words 0x0000..0x000F -> full=1, count=16; a 17th write of 0xFFFF -> overflow=1; 16 reads return 0x0000..0x000F in order.
REQ-033 Read on empty -> underflow=1, uo_out unchanged; simultaneous read+write on empty with 0xABCD -> count=1, and the next read returns 0xABCD.
REQ-034 Fill to 16, then 20 cycles of simultaneous read+write of an incrementing pattern -> count stays 16, data stays in order across pointer wrap, and overflow stays 0.
REQ-035 Write 5 words, assert flush, or assert reset mid-stream -> count=0 and empty=1; ena=0 with wr_en=1 -> count unchanged.
